// File: rtl/ctr_table_if.sv
// ctr_table_if: bundles every non-clock signal of the counter-table
// controller.
//   master - the surrounding logic: the branch-predictor lookup/update
//            requester together with the SRAM array. It drives the
//            requests and arr_r_data.
//   slave  - ctr_table_ctrl. It drives the handshake readies, the
//            predict response and the array read/write port.
// Signal groups:
//   flush, init_done                                    table control/status
//   pred_valid/ready/addr, pred_resp_valid/ctr/taken    predict lookup
//   upd_valid/ready/addr/taken                          update request
//   arr_r_en/addr/data, arr_w_en/addr/data/mask         array ports
interface ctr_table_if #(
  parameter int ADDR_W = 9,
  parameter int CTR_W  = 2
);
  logic              flush;
  logic              init_done;

  logic              pred_valid;
  logic              pred_ready;
  logic [ADDR_W-1:0] pred_addr;
  logic              pred_resp_valid;
  logic [CTR_W-1:0]  pred_resp_ctr;
  logic              pred_resp_taken;

  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_taken;

  logic              arr_r_en;
  logic [ADDR_W-1:0] arr_r_addr;
  logic [CTR_W-1:0]  arr_r_data;
  logic              arr_w_en;
  logic [ADDR_W-1:0] arr_w_addr;
  logic [CTR_W-1:0]  arr_w_data;
  logic              arr_w_mask;

  modport master (
    output flush, pred_valid, pred_addr, upd_valid, upd_addr, upd_taken,
           arr_r_data,
    input  init_done, pred_ready, pred_resp_valid, pred_resp_ctr,
           pred_resp_taken, upd_ready, arr_r_en, arr_r_addr, arr_w_en,
           arr_w_addr, arr_w_data, arr_w_mask
  );

  modport slave (
    input  flush, pred_valid, pred_addr, upd_valid, upd_addr, upd_taken,
           arr_r_data,
    output init_done, pred_ready, pred_resp_valid, pred_resp_ctr,
           pred_resp_taken, upd_ready, arr_r_en, arr_r_addr, arr_w_en,
           arr_w_addr, arr_w_data, arr_w_mask
  );
endinterface

// File: rtl/ctr_table_ctrl.sv
// ctr_table_ctrl: sequencer for one saturating-counter table SRAM
// (1 read port with 1-cycle registered read, 1 masked write port).
// After reset or flush it sweeps every entry to INIT_VAL, then shares the
// read port between predict lookups and update read-modify-writes.
// Updates are saturating +1/-1, with a last-write bypass so results never
// depend on the array's read-during-write behaviour.
// Ports:
//   clock    in   sole clock, all state on posedge
//   reset_n  in   asynchronous active-low reset
//   bus      ctr_table_if.slave:
//            flush (in), init_done (out)
//            pred_valid/pred_addr (in), pred_ready (out)
//            pred_resp_valid/pred_resp_ctr/pred_resp_taken (out)
//            upd_valid/upd_addr/upd_taken (in), upd_ready (out)
//            arr_r_en/arr_r_addr (out), arr_r_data (in)
//            arr_w_en/arr_w_addr/arr_w_data/arr_w_mask (out)
module ctr_table_ctrl #(
  parameter int               ADDR_W       = 9,
  parameter int               DEPTH        = 512,
  parameter int               CTR_W        = 2,
  parameter logic [CTR_W-1:0] INIT_VAL     = CTR_W'(2'b10),
  parameter int               STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  ctr_table_if.slave bus
);

  localparam int                SW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]     LIMIT    = SW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_INIT  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
    return (v == CTR_MAX) ? v : v + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] v);
    return (v == '0) ? v : v - CTR_W'(1);
  endfunction

  // The array may return stale data for an entry written in the same cycle
  // the read was issued; the last-write register holds that newer value.
  function automatic logic [CTR_W-1:0] bypass(
    input logic [ADDR_W-1:0] a,
    input logic              wv,
    input logic [ADDR_W-1:0] wa,
    input logic [CTR_W-1:0]  wd,
    input logic [CTR_W-1:0]  rd
  );
    return (wv && (wa == a)) ? wd : rd;
  endfunction

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_idx, init_idx_nxt;

  logic              hold_v;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_taken;
  logic [SW-1:0]     starve;

  logic              s2_v;
  logic [ADDR_W-1:0] s2_addr;
  logic              s2_taken;

  logic              pr_v;
  logic [ADDR_W-1:0] pr_addr;

  logic              lw_v;
  logic [ADDR_W-1:0] lw_addr;
  logic [CTR_W-1:0]  lw_data;

  logic              run;
  logic              starved;
  logic              block;
  logic              issue;
  logic              pred_ready;
  logic              pred_fire;
  logic              upd_ready;
  logic              upd_fire;
  logic [CTR_W-1:0]  old_ctr;
  logic [CTR_W-1:0]  new_ctr;
  logic [CTR_W-1:0]  resp_ctr;

  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [CTR_W-1:0]  w_data;

  // ---------------------------------------------------------------------
  // FSM: reset -> init sweep -> run
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RESET;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    case (state)
      S_RESET: state_nxt = S_INIT;
      S_INIT: begin
        if (bus.flush) begin
          init_idx_nxt = '0;
        end else if (init_idx == LAST_IDX) begin
          state_nxt    = S_RUN;
          init_idx_nxt = '0;
        end else begin
          init_idx_nxt = init_idx + ADDR_W'(1);
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_nxt    = S_INIT;
          init_idx_nxt = '0;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // ---------------------------------------------------------------------
  // Read-port arbitration (stage 1)
  // ---------------------------------------------------------------------
  // Predict normally wins; once a pending update has been blocked
  // STARVE_LIMIT cycles, pred_ready drops and the update takes the port.
  assign run        = (state == S_RUN);
  assign starved    = hold_v && (starve >= LIMIT);
  assign block      = bus.pred_valid && (starve < LIMIT);
  assign issue      = run && hold_v && !block;
  assign pred_ready = run && !starved;
  assign pred_fire  = bus.pred_valid && pred_ready;
  // An update accepted in a flush cycle would be discarded by the flush,
  // so it is not accepted at all.
  assign upd_ready  = run && !bus.flush && (!hold_v || issue);
  assign upd_fire   = bus.upd_valid && upd_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_v <= 1'b0;
      starve <= '0;
      s2_v   <= 1'b0;
      pr_v   <= 1'b0;
      lw_v   <= 1'b0;
    end else begin
      if (bus.flush)    hold_v <= 1'b0;
      else if (upd_fire) hold_v <= 1'b1;
      else if (issue)    hold_v <= 1'b0;

      if (bus.flush || !hold_v || issue) starve <= '0;
      else if (starve < LIMIT)           starve <= starve + SW'(1);

      s2_v <= issue && !bus.flush;
      pr_v <= pred_fire;
      lw_v <= w_en;
    end
  end

  always_ff @(posedge clock) begin
    if (upd_fire) begin
      hold_addr  <= bus.upd_addr;
      hold_taken <= bus.upd_taken;
    end
    if (issue) begin
      s2_addr  <= hold_addr;
      s2_taken <= hold_taken;
    end
    if (pred_fire) pr_addr <= bus.pred_addr;
    if (w_en) begin
      lw_addr <= w_addr;
      lw_data <= w_data;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: read data returns, modify, write back
  // ---------------------------------------------------------------------
  assign old_ctr  = bypass(s2_addr, lw_v, lw_addr, lw_data, bus.arr_r_data);
  assign new_ctr  = s2_taken ? sat_inc(old_ctr) : sat_dec(old_ctr);
  assign resp_ctr = pr_v ? bypass(pr_addr, lw_v, lw_addr, lw_data, bus.arr_r_data)
                         : '0;

  always_comb begin
    r_en   = 1'b0;
    r_addr = '0;
    w_en   = 1'b0;
    w_addr = '0;
    w_data = '0;
    if (state == S_INIT) begin
      w_en   = 1'b1;
      w_addr = init_idx;
      w_data = INIT_VAL;
    end else if (run) begin
      if (pred_fire) begin
        r_en   = 1'b1;
        r_addr = bus.pred_addr;
      end else if (issue) begin
        r_en   = 1'b1;
        r_addr = hold_addr;
      end
      if (s2_v && !bus.flush) begin
        w_en   = 1'b1;
        w_addr = s2_addr;
        w_data = new_ctr;
      end
    end
  end

  assign bus.init_done       = run;
  assign bus.pred_ready      = pred_ready;
  assign bus.upd_ready       = upd_ready;
  assign bus.pred_resp_valid = pr_v;
  assign bus.pred_resp_ctr   = resp_ctr;
  assign bus.pred_resp_taken = resp_ctr[CTR_W-1];
  assign bus.arr_r_en        = r_en;
  assign bus.arr_r_addr      = r_addr;
  assign bus.arr_w_en        = w_en;
  assign bus.arr_w_addr      = w_addr;
  assign bus.arr_w_data      = w_data;
  assign bus.arr_w_mask      = 1'b1;

endmodule
